// File: rtl/uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm
//   Frame sequencer for the UART receiver. Detects the start-bit falling edge,
//   runs the oversampling edge counter and the bit counter, and drives the
//   enables of the sampler, start/parity/stop checkers and deserializer.
//   Bad frames (start glitch, parity error, stop error) are dropped; a good
//   frame produces a single-cycle data_valid in the first IDLE cycle.
//
// Ports
//   clk_based_on_prescale : oversampling clock (prescale ticks per bit)
//   asy_reset             : async active-low reset
//   rx_in                 : synchronized serial line, idle high
//   prescale              : oversampling ratio (8/16/32); changed only in IDLE
//   par_en                : frame carries a parity bit
//   start_glitch/par_err/stop_err : checker flags, sampled on the last edge
//   edge_cnt, bit_cnt     : position within the bit / within the frame
//   data_samp_en, start_check_enable, deser_en, par_chk_en, stop_chk_en
//   data_valid            : one-cycle good-frame strobe
//   All outputs are registered.
// ---------------------------------------------------------------------------
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk_based_on_prescale,
  input  logic                  asy_reset,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  start_glitch,
  input  logic                  par_err,
  input  logic                  stop_err,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  data_samp_en,
  output logic                  start_check_enable,
  output logic                  deser_en,
  output logic                  par_chk_en,
  output logic                  stop_chk_en,
  output logic                  data_valid
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PRESCALE_W-1:0] w_edge_nxt;
  logic [3:0]            w_bit_nxt;
  logic                  w_last_edge;
  logic                  w_deser_nxt;
  logic                  w_dv_nxt;
  logic [PRESCALE_W-1:0] w_last_pos;

  assign w_last_pos = prescale - PRESCALE_W'(1);
  // >= rather than == so the counter always wraps even with a bad prescale.
  assign w_last_edge = (edge_cnt >= w_last_pos);

  always_comb begin
    w_state_nxt = r_state;
    w_edge_nxt  = edge_cnt;
    w_bit_nxt   = bit_cnt;
    if (r_state == S_IDLE) begin
      w_edge_nxt = '0;
      w_bit_nxt  = '0;
      if (!rx_in) w_state_nxt = S_START;
    end else begin
      if (w_last_edge) begin
        w_edge_nxt = '0;
        w_bit_nxt  = bit_cnt + 4'd1;
      end else begin
        w_edge_nxt = edge_cnt + PRESCALE_W'(1);
      end
      case (r_state)
        S_START:  if (w_last_edge) w_state_nxt = start_glitch ? S_IDLE : S_DATA;
        // >= keeps the FSM moving even if the count ever overshoots.
        S_DATA:   if (w_last_edge && (bit_cnt >= 4'(DATA_WIDTH)))
                    w_state_nxt = par_en ? S_PARITY : S_STOP;
        S_PARITY: if (w_last_edge) w_state_nxt = par_err ? S_IDLE : S_STOP;
        S_STOP:   if (w_last_edge) w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
    // Counters always read 0 while idle, including on abort paths.
    if (w_state_nxt == S_IDLE) begin
      w_edge_nxt = '0;
      w_bit_nxt  = '0;
    end
  end

  // Outputs are registered from next-state values so they line up with the
  // state they describe; deser_en lands on the last edge of each data bit.
  assign w_deser_nxt = (w_state_nxt == S_DATA) && (w_edge_nxt >= w_last_pos);
  assign w_dv_nxt    = (r_state == S_STOP) && w_last_edge && !stop_err;

  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) begin
      r_state            <= S_IDLE;
      edge_cnt           <= '0;
      bit_cnt            <= '0;
      data_samp_en       <= 1'b0;
      start_check_enable <= 1'b0;
      deser_en           <= 1'b0;
      par_chk_en         <= 1'b0;
      stop_chk_en        <= 1'b0;
      data_valid         <= 1'b0;
    end else begin
      r_state            <= w_state_nxt;
      edge_cnt           <= w_edge_nxt;
      bit_cnt            <= w_bit_nxt;
      data_samp_en       <= (w_state_nxt != S_IDLE);
      start_check_enable <= (w_state_nxt == S_START);
      deser_en           <= w_deser_nxt;
      par_chk_en         <= (w_state_nxt == S_PARITY);
      stop_chk_en        <= (w_state_nxt == S_STOP);
      data_valid         <= w_dv_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en, start_glitch, par_err, stop_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       data_samp_en, start_check_enable, deser_en;
  logic       par_chk_en, stop_chk_en, data_valid;

  int checks = 0;
  int errors = 0;

  uart_rx_fsm #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .clk_based_on_prescale(clk),
    .asy_reset(rst_n),
    .rx_in(rx_in),
    .prescale(prescale),
    .par_en(par_en),
    .start_glitch(start_glitch),
    .par_err(par_err),
    .stop_err(stop_err),
    .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt),
    .data_samp_en(data_samp_en),
    .start_check_enable(start_check_enable),
    .deser_en(deser_en),
    .par_chk_en(par_chk_en),
    .stop_chk_en(stop_chk_en),
    .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  // Cumulative event counters; the directed sequence takes deltas.
  int   deser_cnt = 0, dv_cnt = 0, par_cyc = 0, stop_cyc = 0;
  int   deser_bad = 0, dv_long = 0;
  logic dv_prev = 1'b0;
  always @(negedge clk) begin
    if (deser_en) deser_cnt++;
    if (data_valid) dv_cnt++;
    if (par_chk_en) par_cyc++;
    if (stop_chk_en) stop_cyc++;
    if (deser_en && (edge_cnt != prescale - 6'd1)) deser_bad++;
    if (data_valid && dv_prev) dv_long++;
    dv_prev = data_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sends one frame starting now; n = cycles from entering START until
  // data_valid is seen (-1 if it never appears within maxc cycles).
  task automatic run_frame(input int p, input logic [7:0] d, input logic pe,
                           input int maxc, output int n);
    logic [11:0] fb;
    int nb;
    fb = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[i+1] = d[i];
    if (pe) fb[9] = ^d;
    nb = 10 + int'(pe);
    rx_in = 1'b0;
    step();
    n = -1;
    for (int k = 1; k <= maxc && n < 0; k++) begin
      rx_in = (k / p < nb) ? fb[k / p] : 1'b1;
      step();
      if (data_valid) n = k;
    end
    rx_in = 1'b1;
  endtask

  initial begin
    int n, d0, v0, p0, s0;
    rst_n = 1'b0; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0;
    start_glitch = 1'b0; par_err = 1'b0; stop_err = 1'b0;

    // Reset state
    #23;
    chk("rst_edge_cnt", 32'(edge_cnt), 0);
    chk("rst_bit_cnt", 32'(bit_cnt), 0);
    chk("rst_samp_en", 32'(data_samp_en), 0);
    chk("rst_data_valid", 32'(data_valid), 0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("idle_samp_en", 32'(data_samp_en), 0);

    // Frame 1: P=8, no parity, 0xA5
    d0 = deser_cnt; v0 = dv_cnt;
    rx_in = 1'b0; step();
    chk("f1_start_samp", 32'(data_samp_en), 1);
    chk("f1_start_chk", 32'(start_check_enable), 1);
    chk("f1_start_edge", 32'(edge_cnt), 0);
    rx_in = 1'b1;
    repeat (3) step();
    chk("f1_edge_cnt3", 32'(edge_cnt), 3);
    // continue from cycle 3 with the remaining frame bits
    begin
      logic [9:0] fb;
      fb = 10'b1_1010_0101_0;
      n = -1;
      for (int k = 4; k <= 200 && n < 0; k++) begin
        rx_in = (k / 8 < 10) ? fb[k / 8] : 1'b1;
        step();
        if (k == 8) chk("f1_data_bit_cnt", 32'(bit_cnt), 1);
        if (data_valid) n = k;
      end
    end
    chk("f1_latency", n, 80);
    chk("f1_deser_pulses", deser_cnt - d0, 8);
    chk("f1_idle_edge", 32'(edge_cnt), 0);
    step();
    chk("f1_dv_one_cycle", 32'(data_valid), 0);
    chk("f1_back_idle", 32'(data_samp_en), 0);
    chk("f1_dv_count", dv_cnt - v0, 1);

    // Frame 2: P=16, parity, 0x3C
    prescale = 6'd16; par_en = 1'b1;
    d0 = deser_cnt; v0 = dv_cnt; p0 = par_cyc; s0 = stop_cyc;
    run_frame(16, 8'h3C, 1'b1, 300, n);
    chk("f2_latency", n, 176);
    step();
    chk("f2_par_cycles", par_cyc - p0, 16);
    chk("f2_stop_cycles", stop_cyc - s0, 16);
    chk("f2_deser_pulses", deser_cnt - d0, 8);
    chk("f2_dv_count", dv_cnt - v0, 1);

    // Start glitch: P=8, rx low for 2 cycles
    prescale = 6'd8; par_en = 1'b0; start_glitch = 1'b1;
    d0 = deser_cnt; v0 = dv_cnt;
    rx_in = 1'b0; step();
    step();
    rx_in = 1'b1;
    n = 1;
    while (data_samp_en && n < 50) begin step(); n++; end
    chk("glitch_abort_cycles", n, 8);
    chk("glitch_no_deser", deser_cnt - d0, 0);
    repeat (3) step();
    chk("glitch_no_dv", dv_cnt - v0, 0);
    start_glitch = 1'b0;

    // Parity error abort
    par_en = 1'b1; par_err = 1'b1;
    v0 = dv_cnt; p0 = par_cyc; s0 = stop_cyc;
    run_frame(8, 8'h5A, 1'b1, 120, n);
    chk("perr_no_dv_seen", n, 32'hFFFF_FFFF);
    chk("perr_par_cycles", par_cyc - p0, 8);
    chk("perr_no_stop_chk", stop_cyc - s0, 0);
    chk("perr_idle", 32'(data_samp_en), 0);
    par_err = 1'b0; par_en = 1'b0;

    // Stop error, then two good frames back to back
    stop_err = 1'b1;
    v0 = dv_cnt; s0 = stop_cyc;
    run_frame(8, 8'hFF, 1'b0, 100, n);
    chk("serr_no_dv", dv_cnt - v0, 0);
    chk("serr_stop_cycles", stop_cyc - s0, 8);
    stop_err = 1'b0;
    run_frame(8, 8'h00, 1'b0, 100, n);
    chk("b2b_first_latency", n, 80);
    run_frame(8, 8'h81, 1'b0, 100, n);
    chk("b2b_second_latency", n, 80);
    step();
    chk("b2b_dv_count", dv_cnt - v0, 2);

    // Async reset mid-DATA at bit_cnt=4
    rx_in = 1'b0; step();
    n = 0;
    while (bit_cnt != 4'd4 && n < 100) begin step(); n++; end
    chk("mid_reached_bit4", 32'(bit_cnt), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_edge", 32'(edge_cnt), 0);
    chk("mid_rst_bit", 32'(bit_cnt), 0);
    chk("mid_rst_samp", 32'(data_samp_en), 0);
    chk("mid_rst_deser", 32'(deser_en), 0);
    rx_in = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    prescale = 6'd32;
    v0 = dv_cnt;
    run_frame(32, 8'hC3, 1'b0, 400, n);
    chk("p32_latency", n, 320);
    repeat (3) step();
    chk("p32_dv_count", dv_cnt - v0, 1);

    chk("deser_only_on_last_edge", deser_bad, 0);
    chk("dv_never_two_cycles", dv_long, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
